ysyx_23060096_ifu: RTL



---
 rtl/ysyx_23060096_ifu_pkg.sv | 20 ++
 rtl/ysyx_23060096_ifu.sv | 127 ++++++++++++
 2 files changed

// File: rtl/ysyx_23060096_ifu_pkg.sv
// Shared fetch-unit types and constants: state encoding, reset PC, fault NOP.
package ysyx_23060096_ifu_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] IFU_RESET_PC = 32'h8000_0000;
  localparam logic [XLEN-1:0] IFU_NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_OUT   = 2'd2,
    S_DRAIN = 2'd3
  } fetch_state_e;

  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_23060096_ifu.sv
// Instruction fetch: one outstanding imem request, if_valid two cycles after a zero-wait handshake.
// Decode backpressure holds the instruction in S_OUT; redirects abandon in-flight work via S_DRAIN.
module ysyx_23060096_ifu
  import ysyx_23060096_ifu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = IFU_RESET_PC,
  parameter logic [XLEN-1:0] NOP_INST = IFU_NOP_INST
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            imem_resp_err,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_inst,
  output logic [XLEN-1:0] if_pc,
  output logic            if_fault,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] ipc_q, ipc_d;
  logic            fault_q, fault_d;
  logic            mis_pend_q, mis_pend_d;
  logic            req_hs;
  logic            resp_outstanding;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      inst_q     <= '0;
      ipc_q      <= '0;
      fault_q    <= 1'b0;
      mis_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      ipc_q      <= ipc_d;
      fault_q    <= fault_d;
      mis_pend_q <= mis_pend_d;
    end
  end

  assign req_hs = (state_q == S_REQ) && imem_req_ready;

  // A response is still owed after this cycle unless it arrives right now.
  assign resp_outstanding = req_hs ||
                            (((state_q == S_WAIT) || (state_q == S_DRAIN)) && !imem_resp_valid);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    ipc_d      = ipc_q;
    fault_d    = fault_q;
    mis_pend_d = mis_pend_q;
    if (redirect_valid) begin
      pc_d       = redirect_pc;
      mis_pend_d = is_misaligned(redirect_pc) && resp_outstanding;
      if (resp_outstanding) begin
        state_d = S_DRAIN;
      end else if (is_misaligned(redirect_pc)) begin
        state_d = S_OUT;
        inst_d  = NOP_INST;
        ipc_d   = redirect_pc;
        fault_d = 1'b1;
      end else begin
        // Includes S_DRAIN whose pending response lands this cycle: nothing left to wait for.
        state_d = S_REQ;
      end
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (imem_req_ready) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            state_d = S_OUT;
            inst_d  = imem_resp_err ? NOP_INST : imem_resp_data;
            ipc_d   = pc_q;
            fault_d = imem_resp_err;
          end
        end
        S_OUT: begin
          if (if_ready) begin
            state_d = S_REQ;
            pc_d    = pc_q + 32'd4;
          end
        end
        S_DRAIN: begin
          if (imem_resp_valid) begin
            mis_pend_d = 1'b0;
            if (mis_pend_q) begin
              state_d = S_OUT;
              inst_d  = NOP_INST;
              ipc_d   = pc_q;
              fault_d = 1'b1;
            end else begin
              state_d = S_REQ;
            end
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_comb begin
    imem_req_valid = rst_n && (state_q == S_REQ);
    if_valid       = (state_q == S_OUT);
  end

  assign imem_req_addr = pc_q;
  assign if_inst       = inst_q;
  assign if_pc         = ipc_q;
  assign if_fault      = fault_q;

endmodule
